// File: rtl/dmem_arbiter_pkg.sv
// Shared constants and the address legality check for the data-memory arbiter.
package dmem_arbiter_pkg;

  localparam int DMEM_BYTES       = 8192;
  localparam int DMEM_WORDS       = 2048;
  localparam int WORD_OFFSET_BITS = 2;

  localparam int PORT_CPU = 0;
  localparam int PORT_DMA = 1;

  // Callers zero-extend to 64 bits so one function serves any address width.
  function automatic logic addr_err(input logic [63:0] addr, input logic [63:0] limit);
    return (addr[WORD_OFFSET_BITS-1:0] != '0) || (addr >= limit);
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter; the pointer favours the port not granted last.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  logic rr_ptr;

  // Grant is suppressed during reset so nothing is accepted in a reset cycle.
  always_comb begin
    grant = 2'b00;
    if (!rst) begin
      if (req == 2'b11) grant = rr_ptr ? 2'b10 : 2'b01;
      else              grant = req;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)           rr_ptr <= 1'b0;
    else if (grant[1]) rr_ptr <= 1'b0;
    else if (grant[0]) rr_ptr <= 1'b1;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-port data memory between the CPU (port 0) and DMA (port 1).
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_BYTES = DMEM_BYTES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              resp0_valid,
  output logic [DATA_W-1:0] resp0_rdata,
  output logic              resp0_err,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              resp1_valid,
  output logic [DATA_W-1:0] resp1_rdata,
  output logic              resp1_err,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd
);

  logic [1:0]        grant;
  logic              any_grant;
  logic [ADDR_W-1:0] addr_sel;
  logic              we_sel;
  logic [DATA_W-1:0] wdata_sel;
  logic              err_sel;

  logic [1:0]        resp_valid;
  logic [1:0]        resp_err;
  logic [DATA_W-1:0] resp_rdata [2];

  rr_arbiter2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   ({req1_valid, req0_valid}),
    .grant (grant)
  );

  assign req0_ready = grant[PORT_CPU];
  assign req1_ready = grant[PORT_DMA];

  always_comb begin
    any_grant = |grant;
    addr_sel  = grant[PORT_DMA] ? req1_addr  : req0_addr;
    we_sel    = grant[PORT_DMA] ? req1_we    : req0_we;
    wdata_sel = grant[PORT_DMA] ? req1_wdata : req0_wdata;
    err_sel   = addr_err(64'(addr_sel), 64'(MEM_BYTES));
    // Illegal requests are still accepted but must never write memory.
    mem_a     = any_grant ? addr_sel  : '0;
    mem_wd    = any_grant ? wdata_sel : '0;
    mem_we    = any_grant && we_sel && !err_sel;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid <= '0;
      resp_err   <= '0;
      for (int i = 0; i < 2; i++) resp_rdata[i] <= '0;
    end else begin
      resp_valid <= grant;
      for (int i = 0; i < 2; i++) begin
        if (grant[i]) begin
          resp_err[i]   <= err_sel;
          resp_rdata[i] <= (!err_sel && !we_sel) ? mem_rd : '0;
        end
      end
    end
  end

  assign resp0_valid = resp_valid[PORT_CPU];
  assign resp0_err   = resp_err[PORT_CPU];
  assign resp0_rdata = resp_rdata[PORT_CPU];
  assign resp1_valid = resp_valid[PORT_DMA];
  assign resp1_err   = resp_err[PORT_DMA];
  assign resp1_rdata = resp_rdata[PORT_DMA];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 2048x32 data memory.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req0_we;
  logic [31:0] req0_addr, req0_wdata;
  logic        resp0_valid, resp0_err;
  logic [31:0] resp0_rdata;
  logic        req1_valid, req1_ready, req1_we;
  logic [31:0] req1_addr, req1_wdata;
  logic        resp1_valid, resp1_err;
  logic [31:0] resp1_rdata;
  logic [31:0] mem_a, mem_wd, mem_rd;
  logic        mem_we;

  logic [31:0] mem [0:2047];
  logic        tb_clear, tb_load;
  logic [10:0] tb_idx;
  logic [31:0] tb_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Memory model: combinational read, write at posedge; bench-side clear/preload.
  assign mem_rd = mem[mem_a[12:2]];
  always @(posedge clk) begin
    if (tb_clear) begin
      for (int i = 0; i < 2048; i++) mem[i] <= 32'h0;
    end else if (mem_we) begin
      mem[mem_a[12:2]] <= mem_wd;
    end else if (tb_load) begin
      mem[tb_idx] <= tb_data;
    end
  end

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .resp0_valid(resp0_valid), .resp0_rdata(resp0_rdata), .resp0_err(resp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .resp1_valid(resp1_valid), .resp1_rdata(resp1_rdata), .resp1_err(resp1_err),
    .mem_a(mem_a), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ports();
    req0_valid = 0; req0_we = 0; req0_addr = 0; req0_wdata = 0;
    req1_valid = 0; req1_we = 0; req1_addr = 0; req1_wdata = 0;
  endtask

  task automatic preload(input logic [10:0] idx, input logic [31:0] data);
    tb_load = 1; tb_idx = idx; tb_data = data;
    tick();
    tb_load = 0;
  endtask

  task automatic test_reset();
    rst = 1; tb_clear = 1; tb_load = 0; tb_idx = 0; tb_data = 0;
    idle_ports();
    #1;
    tick();
    tb_clear = 0;
    tick();
    rst = 0;
    #1;
    checks++; if (resp0_valid !== 1'b0) begin errors++; $display("FAIL reset_resp0_valid got %b exp 0", resp0_valid); end
    checks++; if (resp1_valid !== 1'b0) begin errors++; $display("FAIL reset_resp1_valid got %b exp 0", resp1_valid); end
    checks++; if (resp0_rdata !== 32'h0) begin errors++; $display("FAIL reset_resp0_rdata got %h exp 0", resp0_rdata); end
    checks++; if (resp1_err !== 1'b0) begin errors++; $display("FAIL reset_resp1_err got %b exp 0", resp1_err); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %b exp 0", mem_we); end
    checks++; if (mem_a !== 32'h0) begin errors++; $display("FAIL idle_mem_a got %h exp 0", mem_a); end
    $display("txn reset done");
  endtask

  // Both ports hold reads; grants alternate 0,1,0,1 starting with port 0.
  task automatic test_round_robin();
    logic [31:0] exp0, exp1;
    exp0 = 32'hA5A5_0040; exp1 = 32'h5A5A_0080;
    preload(11'd16, exp0);
    preload(11'd32, exp1);
    req0_valid = 1; req0_we = 0; req0_addr = 32'h40;
    req1_valid = 1; req1_we = 0; req1_addr = 32'h80;
    #1;
    for (int i = 0; i < 4; i++) begin
      logic g1;
      g1 = (i % 2 == 1);
      checks++; if (req0_ready !== !g1) begin errors++; $display("FAIL rr_ready0[%0d] got %b exp %b", i, req0_ready, !g1); end
      checks++; if (req1_ready !== g1) begin errors++; $display("FAIL rr_ready1[%0d] got %b exp %b", i, req1_ready, g1); end
      tick();
      checks++; if (resp0_valid !== !g1) begin errors++; $display("FAIL rr_resp0_valid[%0d] got %b exp %b", i, resp0_valid, !g1); end
      checks++; if (resp1_valid !== g1) begin errors++; $display("FAIL rr_resp1_valid[%0d] got %b exp %b", i, resp1_valid, g1); end
      if (g1) begin
        checks++; if (resp1_rdata !== exp1) begin errors++; $display("FAIL rr_resp1_rdata[%0d] got %h exp %h", i, resp1_rdata, exp1); end
      end else begin
        checks++; if (resp0_rdata !== exp0) begin errors++; $display("FAIL rr_resp0_rdata[%0d] got %h exp %h", i, resp0_rdata, exp0); end
      end
      $display("txn rr read grant=%0d", g1 ? 1 : 0);
    end
    idle_ports();
    tick();
    checks++; if ({resp0_valid, resp1_valid} !== 2'b00) begin errors++; $display("FAIL rr_resp_pulse got %b exp 00", {resp0_valid, resp1_valid}); end
  endtask

  task automatic test_read_after_write();
    req1_valid = 1; req1_we = 1; req1_addr = 32'h10; req1_wdata = 32'hDEADBEEF;
    #1;
    checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL raw_ready1 got %b exp 1", req1_ready); end
    checks++; if ({mem_we, mem_a, mem_wd} !== {1'b1, 32'h10, 32'hDEADBEEF}) begin errors++; $display("FAIL raw_mem_drive got we=%b a=%h wd=%h exp we=1 a=10 wd=deadbeef", mem_we, mem_a, mem_wd); end
    tick();
    checks++; if ({resp1_valid, resp1_err, resp1_rdata} !== {1'b1, 1'b0, 32'h0}) begin errors++; $display("FAIL raw_wr_resp got v=%b e=%b d=%h exp v=1 e=0 d=0", resp1_valid, resp1_err, resp1_rdata); end
    idle_ports();
    req0_valid = 1; req0_we = 0; req0_addr = 32'h10;
    tick();
    checks++; if ({resp0_valid, resp0_err, resp0_rdata} !== {1'b1, 1'b0, 32'hDEADBEEF}) begin errors++; $display("FAIL raw_rd_resp got v=%b e=%b d=%h exp v=1 e=0 d=deadbeef", resp0_valid, resp0_err, resp0_rdata); end
    idle_ports();
    $display("txn raw addr=10 data=%h", resp0_rdata);
  endtask

  // Misaligned read and out-of-range write both alias word 0 if mis-decoded.
  task automatic test_illegal();
    preload(11'd0, 32'h1111_1111);
    req0_valid = 1; req0_we = 0; req0_addr = 32'h3;
    #1;
    checks++; if ({req0_ready, mem_we} !== 2'b10) begin errors++; $display("FAIL ill_mis_ready_we got %b exp 10", {req0_ready, mem_we}); end
    tick();
    checks++; if ({resp0_valid, resp0_err, resp0_rdata} !== {1'b1, 1'b1, 32'h0}) begin errors++; $display("FAIL ill_mis_resp got v=%b e=%b d=%h exp v=1 e=1 d=0", resp0_valid, resp0_err, resp0_rdata); end
    req0_we = 1; req0_addr = 32'h2000; req0_wdata = 32'h55;
    #1;
    checks++; if ({req0_ready, mem_we} !== 2'b10) begin errors++; $display("FAIL ill_oor_ready_we got %b exp 10", {req0_ready, mem_we}); end
    tick();
    checks++; if ({resp0_valid, resp0_err, resp0_rdata} !== {1'b1, 1'b1, 32'h0}) begin errors++; $display("FAIL ill_oor_resp got v=%b e=%b d=%h exp v=1 e=1 d=0", resp0_valid, resp0_err, resp0_rdata); end
    req0_we = 0; req0_addr = 32'h2000;
    tick();
    checks++; if ({resp0_err, resp0_rdata} !== {1'b1, 32'h0}) begin errors++; $display("FAIL ill_oor_rd got e=%b d=%h exp e=1 d=0", resp0_err, resp0_rdata); end
    idle_ports();
    #1;
    checks++; if (mem[0] !== 32'h1111_1111) begin errors++; $display("FAIL ill_mem_untouched got %h exp 11111111", mem[0]); end
    $display("txn illegal accesses err=%b", resp0_err);
  endtask

  task automatic test_reset_write();
    rst = 1;
    req1_valid = 1; req1_we = 1; req1_addr = 32'h20; req1_wdata = 32'hCAFE;
    #1;
    checks++; if ({req1_ready, mem_we} !== 2'b00) begin errors++; $display("FAIL rstw_ready_we got %b exp 00", {req1_ready, mem_we}); end
    tick();
    rst = 0;
    idle_ports();
    #1;
    checks++; if (mem[8] !== 32'h0) begin errors++; $display("FAIL rstw_mem20 got %h exp 0", mem[8]); end
    checks++; if ({resp0_valid, resp1_valid, resp0_err, resp0_rdata} !== 35'h0) begin errors++; $display("FAIL rstw_resp_state got v0=%b v1=%b e0=%b d0=%h exp all 0", resp0_valid, resp1_valid, resp0_err, resp0_rdata); end
    // Pointer was 1 before reset; after reset port 0 must win again.
    req0_valid = 1; req1_valid = 1;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL rstw_ptr_cleared got %b exp 10", {req0_ready, req1_ready}); end
    idle_ports();
    $display("txn write during reset blocked");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      req0_valid = 1; req0_we = 1; req0_addr = 32'(i * 4); req0_wdata = 32'(i + 1);
      #1;
      checks++; if ({req0_ready, mem_we} !== 2'b11) begin errors++; $display("FAIL b2b_wr_ready[%0d] got %b exp 11", i, {req0_ready, mem_we}); end
      tick();
      checks++; if (resp0_valid !== 1'b1) begin errors++; $display("FAIL b2b_wr_resp[%0d] got %b exp 1", i, resp0_valid); end
      $display("txn b2b write addr=%h data=%0d", i * 4, i + 1);
    end
    for (int i = 0; i < 3; i++) begin
      req0_valid = 1; req0_we = 0; req0_addr = 32'(i * 4);
      tick();
      checks++; if ({resp0_valid, resp0_rdata} !== {1'b1, 32'(i + 1)}) begin errors++; $display("FAIL b2b_rd[%0d] got v=%b d=%h exp v=1 d=%h", i, resp0_valid, resp0_rdata, i + 1); end
      $display("txn b2b read addr=%h data=%0d", i * 4, resp0_rdata);
    end
    idle_ports();
    tick();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_read_after_write();
    test_illegal();
    test_reset_write();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
